multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM. The instruction is fetched in BEATS memory
// beats of MEM_W bits. Each beat loads one IR slice. The opcode is then
// decoded and the matching execute/memory/writeback sequence is stepped.
// Optional feature: define MULTICYCLE_CTRL_BNE_EN to add a BNE state
// (opcode 000101) that branches when the ALU zero flag is clear.
module multicycle_ctrl #(
    parameter int INSTR_W = 32,
    parameter int MEM_W   = 8,
    localparam int BEATS  = INSTR_W / MEM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic [BEATS-1:0] ir_write,
    output logic             iord,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [3:0]       state_dbg
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_ADDIEX = 4'd8;
    localparam logic [3:0] S_ADDIWB = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_BNE    = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;

    logic [3:0]    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;

    // Output decode view: while reset is held the outputs already show
    // FETCH beat 0, so nothing downstream sees a stale strobe.
    logic [3:0]    st;
    logic [BW-1:0] bt;
    logic          op_legal;

    assign st        = reset ? S_FETCH : state_q;
    assign bt        = reset ? '0 : beat_q;
    assign state_dbg = st;

    // Opcodes that DECODE knows how to dispatch.
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R, OP_ADDI, OP_BEQ, OP_J, OP_LB, OP_SB: op_legal = 1'b1;
`ifdef MULTICYCLE_CTRL_BNE_EN
            OP_BNE: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

    // State and beat registers; synchronous reset wins over any transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic; memory states stall until mem_ready.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_DECODE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:          state_d = S_EXEC;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_LB, OP_SB:  state_d = S_MEMADR;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:        state_d = S_BNE;
`endif
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LB) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
            S_BNE:    state_d = S_FETCH;
`endif
            default: begin
                state_d = S_FETCH;
                beat_d  = '0;
            end
        endcase
    end

    // Moore output decode; only ir_write/pc_en look at mem_ready/zero,
    // and illegal_op looks at the opcode while in DECODE.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = '0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        pc_en      = 1'b0;
        illegal_op = 1'b0;
        case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_en     = mem_ready;
                for (int i = 0; i < BEATS; i++)
                    ir_write[i] = mem_ready && (bt == BW'(i));
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = ~op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_BNE_EN
            S_BNE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_en     = ~zero;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl (INSTR_W=32, MEM_W=8, so 4 fetch beats).
// The reference model treats each instruction as a list of named steps
// (fetch, decode, ...) and expands each step to its output pattern.
module tb_multicycle_ctrl;

    localparam int BEATS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, iord, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, pc_en, illegal_op;
    logic [BEATS-1:0] ir_write;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;

    multicycle_ctrl #(.INSTR_W(32), .MEM_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .iord(iord), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .pc_en(pc_en), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [3:0] ir_write;
        logic       iord;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_en;
        logic       illegal_op;
    } outs_t;

    typedef enum int {K_FETCH, K_DEC, K_MADR, K_MRD, K_MWB, K_MWR, K_EXE,
                      K_AWB, K_AIEX, K_AIWB, K_BR, K_BNE, K_J} kind_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000,
        OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_LB = 6'b100000,
        OP_SB = 6'b101000, OP_BNE = 6'b000101, OP_ILL = 6'b111111;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    kind_t prog[$];
    int beat = 0;
    logic [5:0] next_op = OP_R;
    outs_t obs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cycle, got, exp);
        end
    endtask

    // Instruction = fetch beats, decode, then the class-specific steps.
    task automatic start_instr(input logic [5:0] op);
        prog.delete();
        beat = 0;
        opcode = op;
        prog.push_back(K_FETCH);
        prog.push_back(K_DEC);
        case (op)
            OP_R:    begin prog.push_back(K_EXE);  prog.push_back(K_AWB);  end
            OP_ADDI: begin prog.push_back(K_AIEX); prog.push_back(K_AIWB); end
            OP_BEQ:  prog.push_back(K_BR);
            OP_J:    prog.push_back(K_J);
            OP_LB:   begin prog.push_back(K_MADR); prog.push_back(K_MRD); prog.push_back(K_MWB); end
            OP_SB:   begin prog.push_back(K_MADR); prog.push_back(K_MWR); end
`ifdef MULTICYCLE_CTRL_BNE_EN
            OP_BNE:  prog.push_back(K_BNE);
`endif
            default: ;
        endcase
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_BEQ, OP_J, OP_LB, OP_SB: return 1'b1;
`ifdef MULTICYCLE_CTRL_BNE_EN
            OP_BNE: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t exp_out(input kind_t k, input int b, input bit mr,
                                      input bit z, input logic [5:0] op);
        outs_t o;
        o = '0;
        case (k)
            K_FETCH: begin
                o.mem_read = 1; o.alu_src_b = 2'b01; o.pc_en = mr;
                o.ir_write = mr ? (4'b0001 << b) : 4'b0000;
            end
            K_DEC:  begin o.alu_src_b = 2'b11; o.illegal_op = !is_legal(op); end
            K_MADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            K_MRD:  begin o.mem_read = 1; o.iord = 1; end
            K_MWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            K_MWR:  begin o.mem_write = 1; o.iord = 1; end
            K_EXE:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            K_AWB:  begin o.reg_write = 1; o.reg_dst = 1; end
            K_AIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            K_AIWB: o.reg_write = 1;
            K_BR:   begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = z; end
            K_BNE:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = !z; end
            K_J:    begin o.pc_source = 2'b10; o.pc_en = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // One clock: drive, compare against model at negedge, clock, advance model.
    task automatic cyc(input bit rst, input bit mr, input bit z);
        outs_t e;
        reset = rst; mem_ready = mr; zero = z;
        @(negedge clk);
        obs = {mem_read, mem_write, ir_write, iord, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, pc_en, illegal_op};
        if (rst || prog.size() == 0) e = exp_out(K_FETCH, 0, mr, z, opcode);
        else                         e = exp_out(prog[0], beat, mr, z, opcode);
        chk("outputs", 32'(obs), 32'(e));
        @(posedge clk); #1;
        cycle++;
        if (rst) begin
            start_instr(next_op);
        end else begin
            case (prog[0])
                K_FETCH: if (mr) begin
                    if (beat == BEATS - 1) begin beat = 0; void'(prog.pop_front()); end
                    else beat++;
                end
                K_MRD, K_MWR: if (mr) void'(prog.pop_front());
                default: void'(prog.pop_front());
            endcase
            if (prog.size() == 0) start_instr(next_op);
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 8))
            0: return OP_R;
            1: return OP_ADDI;
            2: return OP_BEQ;
            3: return OP_J;
            4: return OP_LB;
            5: return OP_SB;
            6: return OP_BNE;
            7: return OP_ILL;
            default: return r[5:0];
        endcase
    endfunction

    logic [5:0] lat_op [7];
    int         lat_exp[7];

    initial begin
        int n;
        bit seen;
        lat_op  = '{OP_R, OP_ADDI, OP_BEQ, OP_J, OP_LB, OP_SB, OP_ILL};
        lat_exp = '{BEATS + 3, BEATS + 3, BEATS + 2, BEATS + 2, BEATS + 4, BEATS + 3, BEATS + 1};

        // Reset state, with mem_ready both low and high
        @(posedge clk); #1;
        next_op = OP_R;
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("reset_irw", 32'(obs.ir_write), 32'h1);

        // Full-speed latency of every instruction class
        for (int i = 0; i < 7; i++) begin
            next_op = lat_op[i];
            cyc(1, 1, 0);
            n = 0; seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                cyc(0, 1, 0);
                n++;
                if (n > 1 && obs.ir_write == 4'b0001) seen = 1;
            end
            chk("latency", 32'(seen ? n - 1 : -1), 32'(lat_exp[i]));
        end

        // R with mem_ready low for two cycles on beat 2
        next_op = OP_R;
        cyc(1, 1, 0);
        cyc(0, 1, 0); cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("beat2_resume", 32'(obs.ir_write), 32'h4);
        repeat (5) cyc(0, 1, 0);

        // LB with three wait cycles in MEMRD: 11 cycles total
        next_op = OP_LB;
        cyc(1, 1, 0);
        repeat (6) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("lb_memwb", 32'(obs.mem_to_reg), 32'h1);
        cyc(0, 1, 0);
        chk("lb_total11", 32'(obs.ir_write), 32'h1);

        // BEQ taken / not taken, BNE
        for (int zz = 0; zz < 2; zz++) begin
            next_op = OP_BEQ;
            cyc(1, 1, 0);
            repeat (5) cyc(0, 1, 0);
            cyc(0, 1, 1'(zz));
            chk("beq_pc_en", 32'(obs.pc_en), 32'(zz));
            chk("beq_pc_src", 32'(obs.pc_source), 32'h1);
        end
        next_op = OP_BNE;
        cyc(1, 1, 0);
        repeat (5) cyc(0, 1, 0);
`ifdef MULTICYCLE_CTRL_BNE_EN
        cyc(0, 1, 0);
        chk("bne_pc_en", 32'(obs.pc_en), 32'h1);
`else
        chk("bne_illegal", 32'(obs.illegal_op), 32'h1);
`endif

        // Illegal opcode pulse
        next_op = OP_ILL;
        cyc(1, 1, 0);
        repeat (5) cyc(0, 1, 0);
        chk("illegal_pulse", 32'(obs.illegal_op), 32'h1);
        cyc(0, 1, 0);
        chk("illegal_after", 32'(obs.illegal_op), 32'h0);

        // Reset while stalled in MEMWR
        next_op = OP_SB;
        cyc(1, 1, 0);
        repeat (6) cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("in_memwr", 32'(obs.mem_write), 32'h1);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("rst_memwr_mw", 32'(obs.mem_write), 32'h0);
        chk("rst_memwr_irw", 32'(obs.ir_write), 32'h1);

        // Reset on fetch beat 3
        next_op = OP_R;
        cyc(1, 1, 0);
        repeat (3) cyc(0, 1, 0);
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        chk("rst_beat3_irw", 32'(obs.ir_write), 32'h1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            next_op = pick_op();
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
